// File: rtl/random_delay.sv
// Random delay timer: on start, loads a delay (in ticks) from an upstream
// 7-bit LFSR, counts it down using a TICK_DIV-cycle prescaler, and pulses
// time_out_o for one cycle on expiry. The LFSR runs only while idle.
module random_delay #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [6:0] rnd_in_i,
  output logic       lfsr_en_o,
  output logic       busy_o,
  output logic [6:0] remaining_o,
  output logic       time_out_o
);

  // Prescaler needs at least one bit even when TICK_DIV is 1.
  localparam int unsigned PsW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [6:0]     rem_q, rem_d;
  logic [PsW-1:0] ps_q, ps_d;

  // State, delay counter and prescaler registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ps_q    <= ps_d;
    end
  end

  // Next-state logic: load on start, tick down in COUNT, abort from anywhere.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ps_d    = ps_q;
    unique case (state_q)
      StIdle: begin
        // abort wins over start; a zero draw is bumped to one tick.
        if (start_i && !abort_i) begin
          rem_d   = (rnd_in_i == 7'd0) ? 7'd1 : rnd_in_i;
          ps_d    = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (abort_i) begin
          rem_d   = '0;
          ps_d    = '0;
          state_d = StIdle;
        end else if (ps_q == PsMax) begin
          ps_d = '0;
          if (rem_q != 7'd0) begin
            rem_d = rem_q - 7'd1;
          end
          if (rem_q == 7'd1) begin
            state_d = StDone;
          end
        end else begin
          ps_d = ps_q + PsW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        if (abort_i) begin
          rem_d = '0;
          ps_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        rem_d   = '0;
        ps_d    = '0;
      end
    endcase
  end

  // Outputs decode directly from state; lfsr_en is held low during reset.
  always_comb begin
    lfsr_en_o   = (state_q == StIdle) && !rst;
    busy_o      = (state_q != StIdle);
    time_out_o  = (state_q == StDone);
    remaining_o = rem_q;
  end

endmodule

// File: tb/tb_random_delay.sv
// Directed bench for random_delay: one instance with TICK_DIV=4, one with
// TICK_DIV=1. Inputs change and outputs are sampled on the falling edge.
module tb_random_delay;

  logic       clk;
  logic       rst;
  logic       start4, abort4, lfsr4, busy4, to4;
  logic [6:0] rnd4, rem4;
  logic       start1, abort1, lfsr1, busy1, to1;
  logic [6:0] rnd1, rem1;

  int n_checks;
  int n_pass;

  random_delay #(.TICK_DIV(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start4),
    .abort_i    (abort4),
    .rnd_in_i   (rnd4),
    .lfsr_en_o  (lfsr4),
    .busy_o     (busy4),
    .remaining_o(rem4),
    .time_out_o (to4)
  );

  random_delay #(.TICK_DIV(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start1),
    .abort_i    (abort1),
    .rnd_in_i   (rnd1),
    .lfsr_en_o  (lfsr1),
    .busy_o     (busy1),
    .remaining_o(rem1),
    .time_out_o (to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; rnd4 = 7'd0;
    start1 = 1'b0; abort1 = 1'b0; rnd1 = 7'd0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy4); else n_pass++;
    n_checks++; if (rem4 !== 7'd0) $display("FAIL rst_rem: got %0d want 0", rem4); else n_pass++;
    n_checks++; if (to4 !== 1'b0) $display("FAIL rst_to: got %b want 0", to4); else n_pass++;
    n_checks++; if (lfsr4 !== 1'b0) $display("FAIL rst_lfsr: got %b want 0", lfsr4); else n_pass++;
    n_checks++; if (lfsr1 !== 1'b0) $display("FAIL rst_lfsr1: got %b want 0", lfsr1); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (lfsr4 !== 1'b1) $display("FAIL rst_rel_lfsr: got %b want 1", lfsr4); else n_pass++;
  endtask

  // rnd=3, TICK_DIV=4: remaining 3,2,1,0; time_out after edge E0+12.
  task automatic test_basic_count();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start4 = 1'b1; rnd4 = 7'd3;
    @(negedge clk);
    start4 = 1'b0; rnd4 = 7'd55;
    for (int j = 0; j <= 13; j++) begin
      if (j > 0) @(negedge clk);
      if (to4 === 1'b1) pulses++;
      if (j == 0) begin
        n_checks++; if (rem4 !== 7'd3) $display("FAIL cnt_rem_j0: got %0d want 3", rem4); else n_pass++;
        n_checks++; if (busy4 !== 1'b1) $display("FAIL cnt_busy_j0: got %b want 1", busy4); else n_pass++;
        n_checks++; if (lfsr4 !== 1'b0) $display("FAIL cnt_lfsr_j0: got %b want 0", lfsr4); else n_pass++;
      end
      if (j == 3) begin
        n_checks++; if (rem4 !== 7'd3) $display("FAIL cnt_rem_j3: got %0d want 3", rem4); else n_pass++;
      end
      if (j == 4) begin
        n_checks++; if (rem4 !== 7'd2) $display("FAIL cnt_rem_j4: got %0d want 2", rem4); else n_pass++;
      end
      if (j == 8) begin
        n_checks++; if (rem4 !== 7'd1) $display("FAIL cnt_rem_j8: got %0d want 1", rem4); else n_pass++;
      end
      if (j == 11) begin
        n_checks++; if (to4 !== 1'b0) $display("FAIL cnt_to_j11: got %b want 0", to4); else n_pass++;
      end
      if (j == 12) begin
        n_checks++; if (to4 !== 1'b1) $display("FAIL cnt_to_j12: got %b want 1", to4); else n_pass++;
        n_checks++; if (rem4 !== 7'd0) $display("FAIL cnt_rem_j12: got %0d want 0", rem4); else n_pass++;
        n_checks++; if (busy4 !== 1'b1) $display("FAIL cnt_busy_j12: got %b want 1", busy4); else n_pass++;
      end
      if (j == 13) begin
        n_checks++; if (busy4 !== 1'b0) $display("FAIL cnt_busy_j13: got %b want 0", busy4); else n_pass++;
        n_checks++; if (lfsr4 !== 1'b1) $display("FAIL cnt_lfsr_j13: got %b want 1", lfsr4); else n_pass++;
      end
    end
    n_checks++; if (pulses !== 1) $display("FAIL cnt_pulses: got %0d want 1", pulses); else n_pass++;
  endtask

  // rnd=0 is loaded as 1: time_out after edge E0+4.
  task automatic test_zero_guard();
    @(negedge clk);
    start4 = 1'b1; rnd4 = 7'd0;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) begin
        n_checks++; if (rem4 !== 7'd1) $display("FAIL zero_rem: got %0d want 1", rem4); else n_pass++;
      end
      if (j == 3) begin
        n_checks++; if (to4 !== 1'b0) $display("FAIL zero_to_j3: got %b want 0", to4); else n_pass++;
      end
      if (j == 4) begin
        n_checks++; if (to4 !== 1'b1) $display("FAIL zero_to_j4: got %b want 1", to4); else n_pass++;
      end
      if (j == 5) begin
        n_checks++; if (to4 !== 1'b0) $display("FAIL zero_to_j5: got %b want 0", to4); else n_pass++;
      end
    end
  endtask

  // rnd=100, abort raised after 20 cycles; no pulse afterwards.
  task automatic test_abort();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start4 = 1'b1; rnd4 = 7'd100;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 1; j <= 20; j++) @(negedge clk);
    n_checks++; if (rem4 !== 7'd95) $display("FAIL abort_rem_pre: got %0d want 95", rem4); else n_pass++;
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy4); else n_pass++;
    n_checks++; if (rem4 !== 7'd0) $display("FAIL abort_rem: got %0d want 0", rem4); else n_pass++;
    n_checks++; if (lfsr4 !== 1'b1) $display("FAIL abort_lfsr: got %b want 1", lfsr4); else n_pass++;
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      if (to4 === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL abort_no_to: got %0d pulses want 0", pulses); else n_pass++;
  endtask

  // start while busy is ignored; start+abort in idle loads nothing.
  task automatic test_start_ignored();
    @(negedge clk);
    start4 = 1'b1; rnd4 = 7'd10;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; rnd4 = 7'd50;
    @(negedge clk);
    start4 = 1'b0;
    n_checks++; if (rem4 !== 7'd10) $display("FAIL retrig_rem: got %0d want 10", rem4); else n_pass++;
    abort4 = 1'b1;
    @(negedge clk);
    n_checks++; if (busy4 !== 1'b0) $display("FAIL retrig_abort_busy: got %b want 0", busy4); else n_pass++;
    start4 = 1'b1; rnd4 = 7'd5;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL both_busy: got %b want 0", busy4); else n_pass++;
    n_checks++; if (rem4 !== 7'd0) $display("FAIL both_rem: got %0d want 0", rem4); else n_pass++;
  endtask

  // Reset between edges mid-count, then a fresh start behaves as from power-up.
  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start4 = 1'b1; rnd4 = 7'd20;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 1; j <= 5; j++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL mrst_busy: got %b want 0", busy4); else n_pass++;
    n_checks++; if (rem4 !== 7'd0) $display("FAIL mrst_rem: got %0d want 0", rem4); else n_pass++;
    n_checks++; if (to4 !== 1'b0) $display("FAIL mrst_to: got %b want 0", to4); else n_pass++;
    n_checks++; if (lfsr4 !== 1'b0) $display("FAIL mrst_lfsr: got %b want 0", lfsr4); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (to4 === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL mrst_no_to: got %0d pulses want 0", pulses); else n_pass++;
    start4 = 1'b1; rnd4 = 7'd2;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 7) begin
        n_checks++; if (to4 !== 1'b0) $display("FAIL mrst_re_to_j7: got %b want 0", to4); else n_pass++;
      end
      if (j == 8) begin
        n_checks++; if (to4 !== 1'b1) $display("FAIL mrst_re_to_j8: got %b want 1", to4); else n_pass++;
      end
    end
  endtask

  // TICK_DIV=1, rnd=127: one tick per cycle; abort in DONE keeps the pulse.
  task automatic test_tick_div_one();
    int lfsr_hi;
    lfsr_hi = 0;
    @(negedge clk);
    start1 = 1'b1; rnd1 = 7'd127;
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 0; j <= 127; j++) begin
      if (j > 0) @(negedge clk);
      if (j < 127 && lfsr1 !== 1'b0) lfsr_hi++;
      if (j == 1) begin
        n_checks++; if (rem1 !== 7'd126) $display("FAIL td1_rem_j1: got %0d want 126", rem1); else n_pass++;
      end
      if (j == 126) begin
        n_checks++; if (to1 !== 1'b0) $display("FAIL td1_to_j126: got %b want 0", to1); else n_pass++;
        n_checks++; if (rem1 !== 7'd1) $display("FAIL td1_rem_j126: got %0d want 1", rem1); else n_pass++;
      end
    end
    n_checks++; if (lfsr_hi !== 0) $display("FAIL td1_lfsr: got %0d high cycles want 0", lfsr_hi); else n_pass++;
    abort1 = 1'b1;
    #1;
    n_checks++; if (to1 !== 1'b1) $display("FAIL td1_to_j127: got %b want 1", to1); else n_pass++;
    @(negedge clk);
    abort1 = 1'b0;
    n_checks++; if (busy1 !== 1'b0) $display("FAIL td1_busy_end: got %b want 0", busy1); else n_pass++;
    n_checks++; if (to1 !== 1'b0) $display("FAIL td1_to_end: got %b want 0", to1); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic_count();
    test_zero_guard();
    test_abort();
    test_start_ignored();
    test_mid_reset();
    test_tick_div_one();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/random_delay.md
RANDOM_DELAY -- requirements
Module: random_delay

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per delay tick; legal range 1 to 65535.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin a random delay; sampled only in IDLE.
REQ-005 abort  input  1  cancel the delay in progress; sampled in every state.
REQ-006 rnd_in  input  7  pseudo-random value from the upstream 7-bit LFSR.
REQ-007 lfsr_en  output  1  enable to the upstream LFSR; advances it while this block is idle.
REQ-008 busy  output  1  high while a delay is pending, i.e. state != IDLE.
REQ-009 remaining  output  7  delay ticks still to elapse.
REQ-010 time_out  output  1  one-cycle pulse marking expiry of the delay.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-012 IDLE with start=1 and abort=0 SHALL load remaining <= rnd_in, clear the prescaler and enter COUNT at the same edge.
REQ-013 Zero guard: rnd_in=0 at load SHALL load remaining <= 1.
REQ-014 start SHALL be ignored in COUNT and DONE; no reload, no retrigger.
REQ-015 The prescaler SHALL be $clog2(TICK_DIV) bits wide, with a minimum of 1 bit.
REQ-016 In COUNT the prescaler SHALL increment every cycle.
REQ-017 When the prescaler equals TICK_DIV-1 it SHALL wrap to 0 and remaining SHALL decrement by 1; this is one tick.
REQ-018 TICK_DIV=1 SHALL produce one tick every cycle in COUNT.
REQ-019 A tick that takes remaining from 1 to 0 SHALL move the FSM to DONE at the same edge.
REQ-020 DONE SHALL drive time_out=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-021 time_out SHALL be combinational from state (state==DONE).
REQ-022 Latency: with start sampled at edge E0 and loaded value N, time_out SHALL be high for the single cycle after edge E0+N*TICK_DIV.
REQ-023 abort=1 in COUNT or DONE SHALL return the FSM to IDLE at the next edge with remaining <= 0 and the prescaler cleared.
REQ-024 An abort taking effect in DONE SHALL still leave that cycle's time_out visible, because the pulse is combinational.
REQ-025 abort=1 in IDLE SHALL have priority over start; the FSM stays in IDLE and nothing is loaded.
REQ-026 lfsr_en SHALL be 1 in IDLE and 0 in COUNT and DONE, so the upstream value keeps changing only between draws.
REQ-027 lfsr_en SHALL be forced to 0 while rst=1.
REQ-028 busy SHALL be 0 in IDLE and 1 in COUNT and DONE.
REQ-029 remaining SHALL hold its value between ticks and SHALL never underflow below 0.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, remaining=0, prescaler=0, time_out=0, busy=0 and lfsr_en=0.
REQ-031 rst asserted mid-COUNT or in DONE SHALL discard the delay without producing any time_out pulse.
REQ-032 After rst deasserts, the first start SHALL behave exactly as from power-up.

Verification
REQ-033 TICK_DIV=4, rnd_in=3, start pulse at E0 -> remaining steps 3,2,1,0; time_out high exactly one cycle after edge E0+12; busy drops at E0+13.
REQ-034 TICK_DIV=4, rnd_in=0, start -> value loaded as 1; time_out one cycle after edge E0+4.
REQ-035 TICK_DIV=4, rnd_in=100, abort after 20 cycles -> busy=0 at the next edge; no time_out within the following 500 cycles; lfsr_en returns to 1.
REQ-036 start pulsed again while busy -> remaining unchanged; start and abort together in IDLE -> busy stays 0.
REQ-037 rst pulsed between edges mid-COUNT -> all outputs at reset values before the next edge; no time_out afterwards.
REQ-038 TICK_DIV=1, rnd_in=127, start at E0 -> time_out one cycle after edge E0+127; lfsr_en=0 throughout the count.
